// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one instruction-memory read at a time and
// buffers returned {pc, instr} pairs in a small FIFO for the decoder.
// A flush (taken branch/jump) empties the FIFO and drops any fetch in flight.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [IW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] addr_mem  [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [PW-1:0] head_nxt;
  logic [PW:0]   count_nxt;
  logic          accept;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_C) return '0;
    return p + 1'b1;
  endfunction

  // A new fetch is only taken when idle, a slot is free and no redirect is under way,
  // so the single outstanding read always has room to land.
  assign pc_ready  = !reset && (state == S_IDLE) && (count < DEPTH_C) && !flush;
  assign accept    = pc_valid && pc_ready;
  assign push      = (state == S_WAIT) && mem_rvalid && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign mem_req   = (state == S_REQ);
  assign out_valid = (count != '0);

  // Next head/count: flush wins over push and pop and empties the queue.
  always_comb begin
    head_nxt  = head;
    count_nxt = count;
    if (flush) begin
      head_nxt  = tail;
      count_nxt = '0;
    end else begin
      if (pop) head_nxt = ptr_inc(head);
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // Fetch FSM: one read outstanding; DROP swallows the data of a flushed read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mem_addr <= pc_in;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush)        state <= mem_ack ? S_DROP : S_IDLE;
          else if (mem_ack) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid)   state <= S_IDLE;
          else if (flush)   state <= S_DROP;
        end
        S_DROP: begin
          if (mem_rvalid)   state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_nxt;
      count <= count_nxt;
      if (push) tail <= ptr_inc(tail);
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail]  <= mem_addr;
      instr_mem[tail] <= mem_rdata;
    end
  end

  // Registered head view; bypasses the write port when the pushed entry becomes
  // the head, and holds the last value while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_pc    <= '0;
      out_instr <= '0;
    end else if (count_nxt != '0) begin
      if (push && (head_nxt == tail)) begin
        out_pc    <= mem_addr;
        out_instr <= mem_rdata;
      end else begin
        out_pc    <= addr_mem[head_nxt];
        out_instr <= instr_mem[head_nxt];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: table-driven single fetches, hand-written
// flush/reset/fill sequences, then randomized traffic against a queue model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int IW    = 16;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_DROP = 3;

  logic          clk = 1'b0;
  logic          reset, pc_valid, flush, out_ready, mem_ack, mem_rvalid;
  logic [AW-1:0] pc_in, mem_addr, out_pc;
  logic [IW-1:0] mem_rdata, out_instr;
  logic          pc_ready, mem_req, out_valid;

  instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: transaction phase, latched fetch address, FIFO of entries.
  int          m_phase;
  logic [15:0] m_addr;
  logic [15:0] q_pc[$];
  logic [15:0] q_in[$];
  logic [15:0] m_disp_pc, m_disp_in;

  // Values sampled in the most recent cycle.
  logic        s_pc_ready, s_mem_req, s_out_valid;
  logic [15:0] s_mem_addr, s_out_pc, s_out_instr;
  int          s_count;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    int          ack_dly;
    int          rv_dly;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_addr    = '0;
    q_pc.delete();
    q_in.delete();
    m_disp_pc = '0;
    m_disp_in = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic cycle(input logic rs, input logic pcv, input logic [15:0] pc,
                       input logic fl, input logic ordy, input logic ack,
                       input logic rv, input logic [15:0] rd);
    logic exp_pr;
    bit   pop_m, push_m;
    reset = rs; pc_valid = pcv; pc_in = pc; flush = fl;
    out_ready = ordy; mem_ack = ack; mem_rvalid = rv; mem_rdata = rd;
    @(negedge clk);
    s_pc_ready  = pc_ready;
    s_mem_req   = mem_req;
    s_mem_addr  = mem_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    s_out_instr = out_instr;
    s_count     = int'(dut.count);
    exp_pr = !rs && (m_phase == PH_IDLE) && (q_pc.size() < DEPTH) && !fl;
    chk("pc_ready",  s_pc_ready, exp_pr);
    chk("mem_req",   s_mem_req, m_phase == PH_REQ);
    chk("mem_addr",  s_mem_addr, m_addr);
    chk("out_valid", s_out_valid, q_pc.size() != 0);
    chk("out_pc",    s_out_pc, m_disp_pc);
    chk("out_instr", s_out_instr, m_disp_in);
    chk("count",     s_count, q_pc.size());
    if (rs) begin
      model_reset();
    end else begin
      pop_m  = (q_pc.size() != 0) && ordy && !fl;
      push_m = (m_phase == PH_WAIT) && rv && !fl;
      if (fl) begin
        q_pc.delete();
        q_in.delete();
      end else begin
        if (pop_m) begin
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
        if (push_m) begin
          q_pc.push_back(m_addr);
          q_in.push_back(rd);
        end
      end
      if (q_pc.size() != 0) begin
        m_disp_pc = q_pc[0];
        m_disp_in = q_in[0];
      end
      case (m_phase)
        PH_IDLE: if (pcv && exp_pr) begin m_addr = pc; m_phase = PH_REQ; end
        PH_REQ:  if (fl) m_phase = ack ? PH_DROP : PH_IDLE;
                 else if (ack) m_phase = PH_WAIT;
        PH_WAIT: if (rv) m_phase = PH_IDLE;
                 else if (fl) m_phase = PH_DROP;
        default: if (rv) m_phase = PH_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, ordy, 1'b0, 1'b0, 16'h0);
  endtask

  // Fetch with minimum latency; out_ready is asserted only in the data-return cycle.
  task automatic fetch3(input logic [15:0] pc, input logic [15:0] data, input logic ordy_last);
    cycle(1'b0, 1'b1, pc,    1'b0, 1'b0,      1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0,      1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, ordy_last, 1'b0, 1'b1, data);
  endtask

  initial begin
    vec_t vecs[5];
    int   lat;
    bit   got;
    logic ack_r, rv_r;

    vecs[0] = '{pc: 16'h0000, instr: 16'h1234, ack_dly: 0, rv_dly: 0, exp_lat: 3};
    vecs[1] = '{pc: 16'h00FF, instr: 16'hBEEF, ack_dly: 1, rv_dly: 0, exp_lat: 4};
    vecs[2] = '{pc: 16'h8000, instr: 16'h0001, ack_dly: 0, rv_dly: 2, exp_lat: 5};
    vecs[3] = '{pc: 16'hFFFF, instr: 16'hFFFF, ack_dly: 2, rv_dly: 1, exp_lat: 6};
    vecs[4] = '{pc: 16'h1234, instr: 16'h0000, ack_dly: 0, rv_dly: 0, exp_lat: 3};

    reset = 1'b1; pc_valid = 1'b0; pc_in = '0; flush = 1'b0; out_ready = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then first cycle after deassertion.
    cycle(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
    chk("reset_pc_ready", s_pc_ready, 1'b0);
    idle(1'b0);
    chk("post_reset_pc_ready", s_pc_ready, 1'b1);
    chk("post_reset_out_valid", s_out_valid, 1'b0);

    // Single fetches with varied memory delays.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, vecs[i].pc, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      got = 0;
      lat = 0;
      for (int k = 1; k <= 12 && !got; k++) begin
        ack_r = (k == 1 + vecs[i].ack_dly);
        rv_r  = (k == 2 + vecs[i].ack_dly + vecs[i].rv_dly);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, ack_r, rv_r, rv_r ? vecs[i].instr : 16'h0);
        if (s_out_valid) begin
          got = 1;
          lat = k;
        end
      end
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_out_pc", i), s_out_pc, vecs[i].pc);
      chk($sformatf("vec%0d_out_instr", i), s_out_instr, vecs[i].instr);
      idle(1'b1);
      idle(1'b0);
      chk($sformatf("vec%0d_empty", i), s_out_valid, 1'b0);
    end

    // Fill to DEPTH, then one pop re-enables fetching.
    for (int i = 0; i < 4; i++) fetch3(16'(i), 16'hA000 + 16'(i), 1'b0);
    idle(1'b0);
    chk("fill_count", s_count, 4);
    chk("fill_pc_ready", s_pc_ready, 1'b0);
    chk("fill_head", s_out_pc, 16'h0000);
    idle(1'b1);
    idle(1'b0);
    chk("pop_head", s_out_pc, 16'h0001);
    chk("pop_pc_ready", s_pc_ready, 1'b1);
    // Push and pop together at count = DEPTH-1.
    fetch3(16'h0004, 16'hA004, 1'b1);
    idle(1'b0);
    chk("pushpop_full_count", s_count, 3);
    chk("pushpop_full_head", s_out_pc, 16'h0002);
    repeat (3) idle(1'b1);
    idle(1'b0);
    chk("drain_empty", s_out_valid, 1'b0);
    chk("drain_hold_pc", s_out_pc, 16'h0004);

    // Push and pop together at count = 1, pointers wrap.
    fetch3(16'h0100, 16'h5100, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      fetch3(16'h0100 + 16'(j), 16'h5100 + 16'(j), 1'b1);
      idle(1'b0);
      chk($sformatf("pushpop1_count%0d", j), s_count, 1);
      chk($sformatf("pushpop1_head%0d", j), s_out_pc, 16'h0100 + 16'(j));
      chk($sformatf("pushpop1_instr%0d", j), s_out_instr, 16'h5100 + 16'(j));
    end
    idle(1'b1);
    idle(1'b0);

    // Flush in WAIT before data; late data discarded; next fetch delivered alone.
    cycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
    chk("drop_pc_ready", s_pc_ready, 1'b0);
    chk("drop_mem_req", s_mem_req, 1'b0);
    idle(1'b0);
    chk("flush_wait_empty", s_out_valid, 1'b0);
    fetch3(16'h0040, 16'h4040, 1'b0);
    idle(1'b0);
    chk("after_flush_pc", s_out_pc, 16'h0040);
    chk("after_flush_instr", s_out_instr, 16'h4040);
    chk("after_flush_count", s_count, 1);
    idle(1'b1);
    idle(1'b0);
    chk("after_flush_drain", s_out_valid, 1'b0);

    // Flush in REQ without ack -> straight back to IDLE.
    cycle(1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    idle(1'b0);
    chk("flush_req_noack_mem_req", s_mem_req, 1'b0);
    chk("flush_req_noack_pc_ready", s_pc_ready, 1'b1);

    // Flush in REQ with ack -> DROP until data returns.
    cycle(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(1'b0);
    chk("flush_req_ack_pc_ready", s_pc_ready, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBAD0);
    idle(1'b0);
    chk("flush_req_ack_idle", s_pc_ready, 1'b1);
    chk("flush_req_ack_empty", s_out_valid, 1'b0);

    // Flush in WAIT coinciding with data -> data discarded, IDLE.
    cycle(1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b1, 16'hCAFE);
    idle(1'b0);
    chk("flush_wait_rv_empty", s_out_valid, 1'b0);
    chk("flush_wait_rv_pc_ready", s_pc_ready, 1'b1);

    // Flush overrides pop and pc acceptance; outputs hold last head.
    fetch3(16'h0060, 16'h6060, 1'b0);
    fetch3(16'h0061, 16'h6061, 1'b0);
    cycle(1'b0, 1'b1, 16'h0070, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("flush_blocks_accept", s_pc_ready, 1'b0);
    idle(1'b0);
    chk("flush_idle_out_valid", s_out_valid, 1'b0);
    chk("flush_idle_mem_req", s_mem_req, 1'b0);
    chk("flush_idle_hold_pc", s_out_pc, 16'h0060);

    // Reset during a stalled REQ; a late rvalid afterwards is ignored.
    fetch3(16'h0200, 16'h7200, 1'b0);
    cycle(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("stall_mem_req", s_mem_req, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hEEEE);
    chk("rst_mid_mem_req", s_mem_req, 1'b0);
    chk("rst_mid_out_valid", s_out_valid, 1'b0);
    chk("rst_mid_pc_ready", s_pc_ready, 1'b1);
    chk("rst_mid_mem_addr", s_mem_addr, 16'h0000);
    idle(1'b0);
    chk("late_rvalid_ignored", s_out_valid, 1'b0);

    // Randomized traffic with a random-delay memory responder.
    for (int c = 0; c < 3000; c++) begin
      logic rs_r, pcv_r, fl_r, ordy_r;
      logic [15:0] pc_r, rd_r;
      rs_r   = ($urandom_range(0, 299) == 0);
      pcv_r  = ($urandom_range(0, 3) != 0);
      pc_r   = 16'($urandom);
      fl_r   = ($urandom_range(0, 24) == 0);
      ordy_r = ($urandom_range(0, 2) != 0);
      ack_r  = (m_phase == PH_REQ) && ($urandom_range(0, 1) == 1);
      rv_r   = ((m_phase == PH_WAIT) || (m_phase == PH_DROP)) && ($urandom_range(0, 2) == 0);
      if (m_phase == PH_IDLE && $urandom_range(0, 49) == 0) rv_r = 1'b1;
      rd_r   = 16'($urandom);
      cycle(rs_r, pcv_r, pc_r, fl_r, ordy_r, ack_r, rv_r, rd_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
